// File: rtl/cpu_types_pkg.sv
// Types and constants shared by the fetch stage and the instruction decoder.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam logic [1:0] PCSEL_PLUS4  = 2'b00;
    localparam logic [1:0] PCSEL_REG    = 2'b01;
    localparam logic [1:0] PCSEL_JUMP   = 2'b10;
    localparam logic [1:0] PCSEL_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_EXEC   = 2'b01,
        ST_MEM    = 2'b10,
        ST_HALTED = 2'b11
    } fetch_state_t;

    // Branch displacement in bytes: sign-extended word offset shifted left by two.
    function automatic word_t branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection: sequential, register, jump and branch targets.
module next_pc_mux
    import cpu_types_pkg::*;
(
    input  word_t       pc,
    input  logic [25:0] instr_index,
    input  logic [1:0]  pc_sel,
    input  word_t       rs_data,
    output word_t       pc_plus4,
    output word_t       next_pc
);

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        case (pc_sel)
            PCSEL_PLUS4:  next_pc = pc_plus4;
            PCSEL_REG:    next_pc = rs_data;
            // Jump target keeps the region bits of the delay-slot-free PC+4.
            PCSEL_JUMP:   next_pc = {pc_plus4[31:28], instr_index, 2'b00};
            PCSEL_BRANCH: next_pc = pc_plus4 + branch_offset(instr_index[15:0]);
            default:      next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/sequence stage: owns PC and held instruction, steps FETCH -> EXEC -> (MEM) -> FETCH.
module fetch_sequencer
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  word_t       imemload,
    input  logic        dhit,
    input  logic [1:0]  pc_sel,
    input  logic        memREN,
    input  logic        memWEN,
    input  logic        halt,
    input  word_t       rs_data,
    output logic        imemREN,
    output word_t       imemaddr,
    output word_t       instr,
    output word_t       pc,
    output word_t       pc_plus4,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic        commit,
    output logic        halted
);

    fetch_state_t state_reg;
    word_t        pc_reg;
    word_t        instr_reg;
    logic         halted_reg;
    word_t        next_pc;
    logic         mem_req;

    next_pc_mux u_next_pc_mux (
        .pc          (pc_reg),
        .instr_index (instr_reg[25:0]),
        .pc_sel      (pc_sel),
        .rs_data     (rs_data),
        .pc_plus4    (pc_plus4),
        .next_pc     (next_pc)
    );

    assign mem_req  = memREN | memWEN;
    assign pc       = pc_reg;
    assign imemaddr = pc_reg;
    assign instr    = instr_reg;
    assign halted   = halted_reg;

    // Requests and commit are gated by nRST so an aborted access never leaks a strobe.
    always_comb begin
        imemREN = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        commit  = 1'b0;
        if (nRST) begin
            case (state_reg)
                ST_FETCH: imemREN = 1'b1;
                ST_EXEC:  commit  = ~halt & ~mem_req;
                ST_MEM: begin
                    dmemREN = memREN;
                    dmemWEN = memWEN;
                    commit  = dhit;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg  <= ST_FETCH;
            pc_reg     <= PC_INIT;
            instr_reg  <= '0;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (ihit) begin
                        instr_reg <= imemload;
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // HALT wins over any memory request carried by the same word.
                    if (halt) begin
                        halted_reg <= 1'b1;
                        state_reg  <= ST_HALTED;
                    end else if (mem_req) begin
                        state_reg <= ST_MEM;
                    end else begin
                        pc_reg    <= next_pc;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (dhit) begin
                        pc_reg    <= next_pc;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_HALTED: halted_reg <= 1'b1;
                default:   state_reg  <= ST_FETCH;
            endcase
        end
    end

endmodule
